// File: rtl/xor_pkg.sv
// Shared types and helpers for the frame parity engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xor_pkg;

    // Frame engine states: waiting for first word, mid-frame, result pending
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Widest vector parity_f accepts; narrower callers zero-extend (parity unchanged)
    localparam int PAR_MAX_W = 64;

    // Reduction parity, optionally inverted for odd-parity links
    function automatic logic parity_f(input logic [PAR_MAX_W-1:0] vec, input logic odd);
        return (^vec) ^ odd;
    endfunction

endpackage

// File: rtl/xor_tree_st.sv
// WIDTH-input XOR reduction built from 2-input XOR gates, result optionally inverted.
// Latency: combinational.
// Backpressure: none (pure combinational).
module xor_tree_st #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic             parity
);

    localparam logic ODD_BIT = (ODD != 0);
    localparam int   NODES   = 2 * WIDTH - 1;

    // Heap-ordered full binary tree: nodes 0..WIDTH-2 are gates, the rest are leaves.
    // Each node lives in its own generate scope so no vector feeds back into itself.
    for (genvar k = 0; k < NODES; k++) begin : g_node
        logic v;
        if (k < WIDTH - 1) begin : g_gate
            xor u_xor (v, g_node[2*k+1].v, g_node[2*k+2].v);
        end else begin : g_leaf
            assign v = in_vec[k-(WIDTH-1)];
        end
    end

    // Root of the tree carries the parity of all inputs
    assign parity = g_node[0].v ^ ODD_BIT;

endmodule

// File: rtl/xor_parity_accum.sv
// Frame parity engine: lane XOR, parity bit and word count per frame (PARITY_CHECK_EN adds expected-parity compare).
// Latency: result valid 1 cycle after the closing word is accepted.
// Backpressure: in_ready drops while a result is pending; result held until out_ready.
module xor_parity_accum
    import xor_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int ODD       = 0,
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lanes,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
`ifdef PARITY_CHECK_EN
    ,
    input  logic             in_exp_parity,
    output logic             out_err
`endif
);

    state_e           state;
    logic [WIDTH-1:0] lanes;
    logic [WIDTH-1:0] next_lanes;
    logic [CW-1:0]    count;
    logic [CW-1:0]    next_count;
    logic             overflow;
    logic             accept;
    logic             closing;

    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;

    // Next lane/count values for the word being offered; first word of a frame restarts both
    always_comb begin
        next_lanes = in_data;
        next_count = CW'(1);
        if (state == ACCUM) begin
            next_lanes = lanes ^ in_data;
            next_count = count + CW'(1);
        end
        closing = in_last | (next_count == CW'(MAX_WORDS));
    end

    // Frame FSM plus lane, count and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lanes    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            lanes    <= next_lanes;
            count    <= next_count;
            overflow <= closing & ~in_last;
            state    <= closing ? HOLD : ACCUM;
        end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
        end
    end

    assign out_valid    = (state == HOLD);
    assign out_lanes    = lanes;
    assign out_count    = count;
    assign out_overflow = overflow;

    xor_tree_st #(
        .WIDTH (WIDTH),
        .ODD   (ODD)
    ) u_tree (
        .in_vec (lanes),
        .parity (out_parity)
    );

`ifdef PARITY_CHECK_EN
    localparam logic ODD_BIT = (ODD != 0);
    logic err;

    // Compare final frame parity against the producer's expectation; overflow frames never flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept && closing) begin
            err <= in_last ? (parity_f(PAR_MAX_W'(next_lanes), ODD_BIT) ^ in_exp_parity) : 1'b0;
        end
    end

    assign out_err = err;
`endif

endmodule
